// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the two-requester AHB-Lite request arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ahb_arb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/ahb_arb_pick.sv
// Winner select between req0 and req1; optional round-robin last-grant pointer.
// Latency: combinational select; the pointer updates on the grant edge.
// Backpressure: none; the caller only samples the winner when it can grant.
// Build option: AHB_ARB_ROUND_ROBIN_EN enables the pointer, otherwise req0 has
// fixed priority.
// Ports: HCLK/HRESETn clock and async active-low reset; req0/req1 requests;
//        take = a grant happens this cycle; winner = 0 for req0, 1 for req1.
module ahb_arb_pick (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic winner
);

`ifdef AHB_ARB_ROUND_ROBIN_EN
    // Reset to 1 so requester 0 wins the first tie.
    logic last_gnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_gnt <= 1'b1;
        end else if (take) begin
            last_gnt <= winner;
        end
    end

    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else if (req1) begin
            winner = 1'b1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, HCLK, HRESETn, take};

    assign winner = ~req0 & req1;
`endif

endmodule

// File: rtl/ahb_req_arbiter.sv
// Two-requester AHB-Lite single-transfer bus controller (one transfer in flight).
// Latency: grant edge -> ack after 3 edges with zero waits, +1 per HREADY-low cycle.
// Backpressure: requesters hold req until ack; HREADY low stalls ADDR/DATA phases.
// Build option: AHB_ARB_ROUND_ROBIN_EN selects round-robin arbitration on ties.
// Ports: HCLK/HRESETn; req/write/addr/wdata per requester in, ack/err per
//        requester out, shared rdata, busy; AHB-Lite master bus signals.
module ahb_req_arbiter
    import ahb_arb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter logic [2:0] HSIZE_VAL = HSIZE_WORD
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req0,
    input  logic        req1,
    input  logic        write0,
    input  logic        write1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    state_t      state;
    logic        gnt;
    logic        lat_write;
    logic [31:0] lat_wdata;
    logic        misal;
    logic        winner;
    logic        take;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    assign take = (state == ST_IDLE) && (req0 || req1);

    ahb_arb_pick u_pick (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .req0    (req0),
        .req1    (req1),
        .take    (take),
        .winner  (winner)
    );

    assign sel_write = winner ? write1 : write0;
    assign sel_addr  = winner ? addr1  : addr0;
    assign sel_wdata = winner ? wdata1 : wdata0;

    assign HSIZE     = HSIZE_VAL;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            gnt       <= 1'b0;
            lat_write <= 1'b0;
            lat_wdata <= 32'h0;
            misal     <= 1'b0;
            HADDR     <= 32'h0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= 32'h0;
            rdata     <= 32'h0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses raised on entry to RESP
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        gnt       <= winner;
                        lat_write <= sel_write;
                        lat_wdata <= sel_wdata;
                        misal     <= (sel_addr[1:0] != 2'b00);
                        state     <= ST_ADDR;
                        // A misaligned request keeps the bus idle for its
                        // whole life; it only passes through ADDR to report.
                        if (sel_addr[1:0] == 2'b00) begin
                            HTRANS <= HTRANS_NONSEQ;
                            HADDR  <= sel_addr;
                            HWRITE <= sel_write;
                        end
                    end
                end
                ST_ADDR: begin
                    if (misal) begin
                        state <= ST_RESP;
                        ack0  <= ~gnt;
                        ack1  <= gnt;
                        err0  <= ~gnt;
                        err1  <= gnt;
                    end else if (HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        HWRITE <= 1'b0;
                        if (lat_write) begin
                            HWDATA <= lat_wdata;
                        end
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // First half of a two-cycle error (HRESP=1, HREADY=0)
                    // simply keeps waiting here.
                    if (HREADY) begin
                        if (!lat_write) begin
                            rdata <= HRDATA;
                        end
                        state <= ST_RESP;
                        ack0  <= ~gnt;
                        ack1  <= gnt;
                        err0  <= ~gnt & HRESP;
                        err1  <= gnt & HRESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Randomized self-checking bench for ahb_req_arbiter with a transaction-level model.
// Latency: n/a (bench).
// Backpressure: bench acts as requesters and AHB slave, inserting HREADY waits.
module tb_ahb_req_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req0, req1, write0, write1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1, busy;
    logic [31:0] rdata, HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    ahb_req_arbiter dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int checks = 0;
    int errors = 0;

    // Requester-side model state
    bit          m_req  [2];
    bit          m_wr   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    bit          last_gnt = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        req0 = m_req[0]; write0 = m_wr[0]; addr0 = m_addr[0]; wdata0 = m_wd[0];
        req1 = m_req[1]; write1 = m_wr[1]; addr1 = m_addr[1]; wdata1 = m_wd[1];
    endtask

    task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        m_req[i] = 1'b1; m_wr[i] = wr; m_addr[i] = a; m_wd[i] = d;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    function automatic int pick_model();
        if (m_req[0] && m_req[1]) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
            return last_gnt ? 0 : 1;
`else
            return 0;
`endif
        end
        return m_req[0] ? 0 : 1;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, ".haddr"},  HADDR, 32'h0);
        chk({tag, ".htrans"}, {30'h0, HTRANS}, 32'h0);
        chk({tag, ".hwrite"}, {31'h0, HWRITE}, 32'h0);
        chk({tag, ".hwdata"}, HWDATA, 32'h0);
        chk({tag, ".rdata"},  rdata, 32'h0);
        chk({tag, ".acks"},   {28'h0, ack0, ack1, err0, err1}, 32'h0);
        chk({tag, ".busy"},   {31'h0, busy}, 32'h0);
        chk({tag, ".static"}, {17'h0, HSIZE, HBURST, HPROT, HMASTLOCK},
            {17'h0, 3'b010, 3'b000, 4'b0011, 1'b0});
    endtask

    // One complete transaction from the grant edge (edge 1) through the
    // RESP->IDLE edge. wa = address-phase waits, wdw = data-phase waits.
    task automatic run_one(input string tag, input int wa, input int wdw, input bit er,
                           input bit scramble, input bit drop, input bit hold);
        int          w, k, m, ack_e;
        bit          wr, mis, e_exp;
        logic [31:0] a, d, rd_exp;
        logic [1:0]  exp_trans;
        w   = pick_model();
        last_gnt = w[0];
        wr  = m_wr[w]; a = m_addr[w]; d = m_wd[w];
        mis = (a[1:0] != 2'b00);
        k   = 2 + wa;
        m   = k + 1 + wdw;
        ack_e  = mis ? 2 : m;
        rd_exp = $urandom;
        for (int e = 1; e <= ack_e + 1; e++) begin
            if (!mis && e >= k + 1 && e <= m) begin
                HREADY = (e == m);
                HRESP  = er && (e >= m - 1);
                HRDATA = (e == m) ? rd_exp : $urandom;
            end else if (!mis && e >= 2 && e <= k) begin
                HREADY = (e == k); HRESP = 1'b0; HRDATA = $urandom;
            end else begin
                HREADY = 1'($urandom_range(0, 1)); HRESP = 1'b0; HRDATA = $urandom;
            end
            @(posedge HCLK);
            @(negedge HCLK);
            exp_trans = (!mis && e < k) ? 2'b10 : 2'b00;
            chk({tag, ".htrans"}, {30'h0, HTRANS}, {30'h0, exp_trans});
            if (exp_trans == 2'b10) begin
                chk({tag, ".haddr"},  HADDR, a);
                chk({tag, ".hwrite"}, {31'h0, HWRITE}, {31'h0, wr});
            end else begin
                chk({tag, ".hwrite_idle"}, {31'h0, HWRITE}, 32'h0);
            end
            if (!mis && wr && e >= k && e <= m)
                chk({tag, ".hwdata"}, HWDATA, d);
            chk({tag, ".busy"}, {31'h0, busy}, {31'h0, (e <= ack_e)});
            chk({tag, ".ack"}, {30'h0, ack0, ack1},
                {30'h0, (e == ack_e && w == 0), (e == ack_e && w == 1)});
            if (e == ack_e) begin
                e_exp = mis | er;
                chk({tag, ".err"}, {30'h0, err0, err1},
                    {30'h0, (w == 0) & e_exp, (w == 1) & e_exp});
                if (!mis && !wr) chk({tag, ".rdata"}, rdata, rd_exp);
            end else begin
                chk({tag, ".err_idle"}, {30'h0, err0, err1}, 32'h0);
            end
            if (e == 1 && scramble) begin
                m_addr[w] = $urandom; m_wd[w] = $urandom; m_wr[w] = ~m_wr[w];
                drive_reqs();
            end
            if (e == 1 && drop) begin
                m_req[w] = 1'b0;
                drive_reqs();
            end
            if (e == ack_e) begin
                if (hold) set_req(w, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                else      m_req[w] = 1'b0;
                drive_reqs();
            end
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check_reset_values(tag);
        @(negedge HCLK);
        HRESETn = 1'b1;
        last_gnt = 1'b1;
    endtask

    initial begin
        HRESETn = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = 32'h0; m_wd[i] = 32'h0;
        end
        drive_reqs();
        #2;
        check_reset_values("rst");
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Single zero-wait write
        set_req(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF); drive_reqs();
        run_one("wr0", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Read with two wait states
        set_req(1, 1'b0, 32'h0000_2004, 32'h0); drive_reqs();
        run_one("rd1w2", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two-cycle error response
        set_req(0, 1'b0, 32'h0000_3000, 32'h0); drive_reqs();
        run_one("err", 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Misaligned address
        set_req(0, 1'b1, 32'h0000_1002, 32'h1234_5678); drive_reqs();
        run_one("misal", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Both requesting from reset, both held across acks
        do_reset("rst2");
        set_req(0, 1'b1, 32'h0000_4000, 32'h1111_1111);
        set_req(1, 1'b0, 32'h0000_5000, 32'h0);
        drive_reqs();
        for (int i = 0; i < 4; i++) begin
            m_addr[0][1:0] = 2'b00; m_addr[1][1:0] = 2'b00; drive_reqs();
            run_one("tie", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        m_req[0] = 1'b0; m_req[1] = 1'b0; drive_reqs();
        @(negedge HCLK);
        chk("tie.idle", {31'h0, busy}, 32'h0);

        // Reset while in DATA, then reissue
        set_req(0, 1'b1, 32'h0000_6000, 32'hA5A5_5A5A); drive_reqs();
        HREADY = 1'b1;
        @(posedge HCLK); @(negedge HCLK);
        @(posedge HCLK); @(negedge HCLK);
        chk("mid.busy", {31'h0, busy}, 32'h1);
        HRESETn = 1'b0;
        #1;
        check_reset_values("mid");
        @(posedge HCLK); @(negedge HCLK);
        chk("mid.noack", {30'h0, ack0, ack1}, 32'h0);
        HRESETn = 1'b1;
        last_gnt = 1'b1;
        run_one("reissue", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            int wa, wdw;
            bit er;
            for (int i = 0; i < 2; i++)
                if (!m_req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            drive_reqs();
            if (!m_req[0] && !m_req[1]) begin
                @(posedge HCLK); @(negedge HCLK);
                chk("rnd.idle", {29'h0, busy, HTRANS}, 32'h0);
                set_req(t % 2, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                drive_reqs();
            end
            wa  = $urandom_range(0, 2);
            wdw = $urandom_range(0, 2);
            er  = (wdw >= 1) && ($urandom_range(0, 3) == 0);
            run_one("rnd", wa, wdw, er, 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
